mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative signed multiply/divide responder for the multicycle MIPS core; the execution end of the
//  control unit's MultStart/DivMult request. On a start pulse it latches A/B, runs WIDTH iterations,
//  writes HI/LO, and pulses Done so the control FSM can leave its Mult/Div wait states.
//  Sits beside the ALU; the control unit's mfhi/mflo states read HI/LO through the MemToReg mux.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  Clock      in   1      system clock, rising edge
//  Reset      in   1      asynchronous, active-low reset
//  MultStart  in   1      start request, sampled only in IDLE
//  DivMult    in   1      op select at start: 0 = mult, 1 = div
//  OpA        in   WIDTH  rs value (multiplicand / dividend), signed
//  OpB        in   WIDTH  rt value (multiplier / divisor), signed
//  Busy       out  1      high from the cycle after start through the Done cycle
//  Done       out  1      one-cycle completion pulse
//  DivZero    out  1      one-cycle pulse: div requested with OpB == 0
//  HI         out  WIDTH  mult: product[2W-1:W]; div: remainder
//  LO         out  WIDTH  mult: product[W-1:0];  div: quotient
// BEHAVIOUR
//  - Reset (async, Reset==0): state IDLE; Busy=0, Done=0, DivZero=0, HI=0, LO=0, all datapath regs 0.
//  - Reset mid-operation: aborts immediately, same values; no Done issued.
//  - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//    IDLE: on MultStart=1 latch OpA, OpB, DivMult; record operand signs; load |OpA|, |OpB|; cnt=0.
//          If DivMult=1 and OpB==0: go to DONE with zero-divisor flag set (no CALC).
//    CALC: one iteration per cycle, cnt 0..WIDTH-1, exits after cnt==WIDTH-1.
//          mult: unsigned shift-add on magnitudes into 2W accumulator.
//          div : restoring shift-subtract on magnitudes; quotient bit = ~borrow.
//    FIX : mult: negate 2W product if signA^signB. div: negate quotient if signA^signB;
//          negate remainder if signA (remainder takes dividend sign, quotient truncates toward 0).
//    DONE: HI/LO update on entry edge; Done=1 for this single cycle; DivZero=1 instead if flagged.
//  - Latency: start sampled at edge 0 -> Done high after edge WIDTH+2 (34 for WIDTH=32).
//    Div-by-zero: Done and DivZero high after edge 1; HI/LO keep previous values.
//  - Busy=1 in CALC, FIX, DONE. MultStart while Busy is ignored (not queued).
//  - MultStart in the Done cycle is ignored; accepted from the following IDLE cycle.
//  - Overflow: -2^(W-1) / -1 -> LO = 0x8000_0000, HI = 0; no flag. Mult never overflows (2W result).
//  - Magnitude of -2^(W-1) is held in W+1 bits internally; no truncation before FIX.
//  - HI/LO hold value between operations; only DONE (non-zero-divisor) writes them.
//  - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: MDU state encoding (MDU_IDLE, MDU_CALC, MDU_FIX, MDU_DONE),
//    op codes OP_MULT=1'b0 / OP_DIV=1'b1, WIDTH default constant.
//  - One sub-module: mdu_cond_negate (WIDTH-generic two's-complement negate when neg=1),
//    used for operand abs and result fixup. Everything else inline.
// TESTING
//  1. mult 7 * -3 -> Done at edge 34, HI=0xFFFF_FFFF, LO=0xFFFF_FFEB, Busy high edges 1..34.
//  2. mult 0x8000_0000 * 0x8000_0000 -> HI=0x4000_0000, LO=0x0000_0000.
//  3. div -7 / 2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); div 7 / -2 -> LO=-3, HI=1.
//  4. div 5 / 0 with HI/LO preloaded 1/2 -> DivZero and Done at edge 1, HI=1, LO=2 unchanged.
//  5. div 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0, no DivZero.
//  6. Reset low at edge 10 of a mult -> Busy=0, HI=LO=0 immediately; MultStart during Busy ignored.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control-unit definitions: multiply/divide unit state encoding, op codes and default width.
package mips_ctrl_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_cond_negate.sv
// Two's-complement negate of a WIDTH-bit value when neg is set, pass-through otherwise.
module mdu_cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: magnitudes are processed one bit per cycle,
// signs are applied in a fix-up cycle, and HI/LO/Done are presented one cycle later.
module mult_div_unit
  import mips_ctrl_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             MultStart,
  input  logic             DivMult,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t         state_reg;
  logic               op_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               dz_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH:0]     opb_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quot_reg;
  logic [WIDTH-1:0]   res_hi_reg;
  logic [WIDTH-1:0]   res_lo_reg;

  logic [WIDTH:0]     abs_a;
  logic [WIDTH:0]     abs_b;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // One extra bit so that |-2^(WIDTH-1)| is represented exactly.
  mdu_cond_negate #(.WIDTH(WIDTH + 1)) u_abs_a (
    .value  ({OpA[WIDTH-1], OpA}),
    .neg    (OpA[WIDTH-1]),
    .result (abs_a)
  );

  mdu_cond_negate #(.WIDTH(WIDTH + 1)) u_abs_b (
    .value  ({OpB[WIDTH-1], OpB}),
    .neg    (OpB[WIDTH-1]),
    .result (abs_b)
  );

  mdu_cond_negate #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .value  (prod_reg),
    .neg    (sign_a_reg ^ sign_b_reg),
    .result (prod_fix)
  );

  mdu_cond_negate #(.WIDTH(WIDTH)) u_fix_quot (
    .value  (quot_reg),
    .neg    (sign_a_reg ^ sign_b_reg),
    .result (quot_fix)
  );

  mdu_cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .value  (rem_reg),
    .neg    (sign_a_reg),
    .result (rem_fix)
  );

  // Partial remainder stays below the divisor, so the shifted trial and the
  // difference both fit WIDTH+1 bits; the top bit of diff is the borrow.
  assign shifted = {rem_reg, quot_reg[WIDTH-1]};
  assign diff    = shifted - opb_reg;
  assign borrow  = diff[WIDTH];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= MDU_IDLE;
      op_reg     <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      dz_reg     <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      opb_reg    <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      res_hi_reg <= '0;
      res_lo_reg <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      DivZero    <= 1'b0;
      HI         <= '0;
      LO         <= '0;
    end else begin
      // Outputs trail the state by one cycle; Busy also covers the Done cycle.
      Busy    <= (state_reg != MDU_IDLE);
      Done    <= (state_reg == MDU_DONE);
      DivZero <= (state_reg == MDU_DONE) && dz_reg;

      case (state_reg)
        MDU_IDLE: begin
          if (MultStart && !Busy) begin
            op_reg     <= DivMult;
            sign_a_reg <= OpA[WIDTH-1];
            sign_b_reg <= OpB[WIDTH-1];
            mcand_reg  <= {{(WIDTH-1){1'b0}}, abs_a};
            quot_reg   <= abs_a[WIDTH-1:0];
            opb_reg    <= abs_b;
            prod_reg   <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            if (DivMult == OP_DIV && OpB == '0) begin
              dz_reg    <= 1'b1;
              state_reg <= MDU_DONE;
            end else begin
              dz_reg    <= 1'b0;
              state_reg <= MDU_CALC;
            end
          end
        end

        MDU_CALC: begin
          if (op_reg == OP_DIV) begin
            rem_reg  <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quot_reg <= {quot_reg[WIDTH-2:0], ~borrow};
          end else begin
            if (opb_reg[0]) begin
              prod_reg <= prod_reg + mcand_reg;
            end
            mcand_reg <= mcand_reg << 1;
            opb_reg   <= opb_reg >> 1;
          end
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            state_reg <= MDU_FIX;
          end
        end

        MDU_FIX: begin
          if (op_reg == OP_DIV) begin
            res_hi_reg <= rem_fix;
            res_lo_reg <= quot_fix;
          end else begin
            {res_hi_reg, res_lo_reg} <= prod_fix;
          end
          state_reg <= MDU_DONE;
        end

        MDU_DONE: begin
          if (!dz_reg) begin
            HI <= res_hi_reg;
            LO <= res_lo_reg;
          end
          state_reg <= MDU_IDLE;
        end

        default: state_reg <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against a plain-arithmetic signed model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         MultStart = 1'b0;
  logic         DivMult = 1'b0;
  logic [W-1:0] OpA = '0;
  logic [W-1:0] OpB = '0;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .MultStart (MultStart),
    .DivMult   (DivMult),
    .OpA       (OpA),
    .OpB       (OpB),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Signed reference: 64-bit product, C-style truncating division.
  task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint     la;
    longint     lb;
    logic [63:0] r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    dz = 1'b0;
    if (!op) begin
      r  = la * lb;
      hi = r[63:32];
      lo = r[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
      hi = exp_hi;
      lo = exp_lo;
    end else begin
      r  = la / lb;
      lo = r[31:0];
      r  = la % lb;
      hi = r[31:0];
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'(int'($urandom_range(0, 16)) - 8);
      2:       return '0;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inject, input bit done_start);
    logic [W-1:0] mh;
    logic [W-1:0] ml;
    logic         mdz;
    int           n;
    int           lat;
    bit           seen;
    model(op, a, b, mh, ml, mdz);
    lat = mdz ? 1 : W + 2;
    @(negedge Clock);
    MultStart = 1'b1; DivMult = op; OpA = a; OpB = b;
    @(posedge Clock); #1;
    check("busy_edge0", Busy, 0);
    @(negedge Clock);
    MultStart = 1'b0; DivMult = ~op; OpA = $urandom; OpB = $urandom;
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(posedge Clock); #1;
      n++;
      check("busy_active", Busy, 1);
      if (Done) begin
        seen = 1;
      end else if (inject && n == 4) begin
        @(negedge Clock);
        MultStart = 1'b1; OpA = $urandom; OpB = $urandom;
      end else if (inject && n == 5) begin
        @(negedge Clock);
        MultStart = 1'b0;
      end
    end
    check("latency", n, lat);
    check("divzero", DivZero, mdz);
    check("hi", HI, mh);
    check("lo", LO, ml);
    exp_hi = mh;
    exp_lo = ml;
    if (done_start) begin
      @(negedge Clock);
      MultStart = 1'b1; DivMult = 1'b0; OpA = 32'd3; OpB = 32'd3;
    end
    @(posedge Clock); #1;
    check("done_clear", Done, 0);
    check("busy_clear", Busy, 0);
    if (done_start) begin
      @(negedge Clock);
      MultStart = 1'b0;
      @(posedge Clock); #1;
      check("done_cycle_start_ignored", Busy, 0);
    end
    $display("op=%s a=%h b=%h -> hi=%h lo=%h divzero=%0d latency=%0d inject=%0d",
             op ? "div " : "mult", a, b, HI, LO, DivZero, n, inject);
  endtask

  initial begin
    bit stray;
    #1;
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_divzero", DivZero, 0);
    check("reset_hi", HI, 0);
    check("reset_lo", LO, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1);
    do_op(1'b1, 32'd5, 32'd2, 0, 0);
    do_op(1'b1, 32'd5, 32'd0, 0, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(1'(int'($urandom_range(0, 1))), pick(), pick(), ($urandom_range(0, 3) == 0), 0);
    end

    // Abort a multiply mid-flight after leaving nonzero HI/LO behind.
    do_op(1'b1, 32'd5, 32'd2, 0, 0);
    @(negedge Clock);
    MultStart = 1'b1; DivMult = 1'b0; OpA = 32'd123; OpB = 32'd456;
    @(posedge Clock);
    @(negedge Clock);
    MultStart = 1'b0;
    repeat (10) @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    @(negedge Clock);
    Reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    stray = 0;
    repeat (40) begin
      @(posedge Clock); #1;
      if (Done || Busy) stray = 1;
    end
    check("no_done_after_abort", stray, 0);
    do_op(1'b0, 32'd123, 32'd456, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
